// File: rtl/sort_loader.sv
// sort_loader: packs ELEMS elements of ELEM_W bits, arriving one at a time
// over a valid/ready handshake, into one word for the downstream sorter.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holds valid and data stable
// until that edge. The input side may drain and refill in the same cycle.
// While clear is high, nothing transfers on either side.
module sort_loader #(
  parameter  int ELEM_W = 4,
  parameter  int ELEMS  = 4,
  localparam int W      = ELEM_W * ELEMS,
  localparam int CW     = $clog2(ELEMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [ELEM_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     fill_count,
  output logic              state_dbg
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   fill_q;
  logic            valid_q;
  logic [W-1:0]    data_q;

  logic            in_xfer;
  logic            out_xfer;

  // Ready is open while filling; when full it follows the consumer so a
  // drain and a refill can share one cycle. clear blocks everything.
  always_comb begin
    in_ready = 1'b0;
    if (!clear) begin
      in_ready = (state_q == S_FULL) ? out_ready : 1'b1;
    end
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = valid_q & out_ready & ~clear;

  // Fill/full FSM with registered word, count and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      fill_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      // Abort: drop the count, keep slot contents (they become stale).
      state_q <= S_FILL;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (in_xfer) begin
            for (int s = 0; s < ELEMS; s++) begin
              if (fill_q == CW'(s)) begin
                data_q[s*ELEM_W +: ELEM_W] <= in_data;
              end
            end
            if (fill_q == CW'(ELEMS - 1)) begin
              state_q <= S_FULL;
              valid_q <= 1'b1;
              fill_q  <= CW'(ELEMS);
            end else begin
              fill_q <= fill_q + CW'(1);
            end
          end
        end
        S_FULL: begin
          if (out_xfer) begin
            if (in_xfer) begin
              // Same-cycle drain and refill: the new element opens the next word.
              data_q[ELEM_W-1:0] <= in_data;
              fill_q             <= CW'(1);
              if (ELEMS == 1) begin
                state_q <= S_FULL;
                valid_q <= 1'b1;
              end else begin
                state_q <= S_FILL;
                valid_q <= 1'b0;
              end
            end else begin
              state_q <= S_FILL;
              valid_q <= 1'b0;
              fill_q  <= '0;
            end
          end
        end
        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign fill_count = fill_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sort_loader.sv
// Bench for sort_loader with default parameters (4 x 4-bit elements).
module tb_sort_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic [2:0]  fill_count;
  logic        state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  sort_loader dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fill_count (fill_count),
    .state_dbg  (state_dbg)
  );

  // Clock: posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; registered outputs are settled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one element for one edge (consumer side left as is).
  task automatic feed(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  // Drain one full word with a single out_ready pulse.
  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(fill_count), 32'd0);
  endtask

  // Monitor: every accepted output word is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !clear) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word act=%0h exp=none t=%0t", out_data, $time);
      end else begin
        chk("word", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] gvals[4];
  int k;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data), 32'd0);
    chk("rst_count", 32'(fill_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // ---- Basic fill: 3,1,4,2 back to back, consumer stalled
    exp_q.push_back(16'h2413);
    feed(4'h3); chk("basic_cnt1", 32'(fill_count), 32'd1);
    feed(4'h1); chk("basic_cnt2", 32'(fill_count), 32'd2);
    feed(4'h4); chk("basic_cnt3", 32'(fill_count), 32'd3);
    chk("basic_not_valid", 32'(out_valid), 32'd0);
    feed(4'h2);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data",  32'(out_data), 32'h2413);
    chk("basic_count", 32'(fill_count), 32'd4);
    chk("basic_state", 32'(state_dbg), 32'd1);
    #1;
    chk("basic_in_ready", 32'(in_ready), 32'd0);
    drain();

    // ---- Gapped input: two idle cycles between elements
    gvals[0] = 4'h3; gvals[1] = 4'h1; gvals[2] = 4'h4; gvals[3] = 4'h2;
    exp_q.push_back(16'h2413);
    for (int i = 0; i < 4; i++) begin
      feed(gvals[i]);
      chk("gap_count", 32'(fill_count), 32'(i + 1));
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          chk("gap_hold", 32'(fill_count), 32'(i + 1));
        end
      end
    end
    chk("gap_data", 32'(out_data), 32'h2413);
    drain();

    // ---- Streaming: 12 elements, consumer always ready
    exp_q.push_back(16'h3210);
    exp_q.push_back(16'h7654);
    exp_q.push_back(16'hBA98);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h0;
    #1;
    chk("stream_ready0", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      k = i + 1;
      chk("stream_valid", 32'(out_valid), 32'((k % 4) == 0));
      chk("stream_count", 32'(fill_count), 32'(((k % 4) == 0) ? 4 : (k % 4)));
      if (i == 11) in_valid = 1'b0;
      else         in_data = 4'(i + 1);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    tick();
    out_ready = 1'b0;
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_end_count", 32'(fill_count), 32'd0);

    // ---- Back-pressure while full, then same-cycle drain and refill with F
    exp_q.push_back(16'h6789);
    feed(4'h9); feed(4'h8); feed(4'h7); feed(4'h6);
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data), 32'h6789);
      chk("bp_count", 32'(fill_count), 32'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_refill_count", 32'(fill_count), 32'd1);
    chk("bp_refill_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(16'h321F);
    feed(4'h1); feed(4'h2); feed(4'h3);
    chk("bp_next_data", 32'(out_data), 32'h321F);
    drain();

    // ---- Clear on a partial word
    feed(4'hA); feed(4'hB);
    chk("clr_pre_count", 32'(fill_count), 32'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hE;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_count", 32'(fill_count), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(16'hDCBA);
    feed(4'hA); feed(4'hB); feed(4'hC); feed(4'hD);
    chk("clr_word", 32'(out_data), 32'hDCBA);
    drain();

    // ---- Clear while full with consumer ready: no transfer
    feed(4'h1); feed(4'h2); feed(4'h3); feed(4'h4);
    chk("clrfull_pre", 32'(out_valid), 32'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clrfull_valid", 32'(out_valid), 32'd0);
    chk("clrfull_count", 32'(fill_count), 32'd0);
    chk("clrfull_data",  32'(out_data), 32'h4321);
    chk("clrfull_state", 32'(state_dbg), 32'd0);

    // ---- Asynchronous reset between edges while full
    feed(4'h5); feed(4'h6); feed(4'h7); feed(4'h8);
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  32'(out_data), 32'd0);
    chk("arst_count", 32'(fill_count), 32'd0);
    rst = 1'b0;
    tick();
    exp_q.push_back(16'hA53C);
    feed(4'hC);
    chk("arst_slot0", 32'(out_data), 32'h000C);
    feed(4'h3); feed(4'h5); feed(4'hA);
    drain();

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
